census3x3: RTL and testbench

Streaming 3x3 census transform for 8-bit grayscale video in raster order. Sits after the gray conversion stage and feeds stereo matching and Hamming-cost logic. Uses two internal line buffers of IMAGE_WIDTH pixels. For each completed 3x3 window it emits an 8-bit census code, zero-extended to 16 bits, tagged with the window centre's row/column coordinates.

---
 rtl/census3x3_if.sv | 11 +
 rtl/census3x3.sv | 196 +++++++++++++++++++
 tb/tb_census3x3.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/census3x3_if.sv
// Pixel-in / census-out stream bundle for the 3x3 census block.
// The master drives pixels; the slave (census3x3) returns codes.
interface census3x3_if;
  logic        gray_valid;
  logic [7:0]  gray;
  logic        census_valid;
  logic [15:0] census_out;

  modport master (output gray_valid, output gray, input census_valid, input census_out);
  modport slave  (input gray_valid, input gray, output census_valid, output census_out);
endinterface

// File: rtl/census3x3.sv
// Streaming 3x3 census transform over raster-order 8-bit pixels.
// Two line buffers plus three column registers form the window; the code is emitted 2 cycles after acceptance.
module census3x3 #(
  parameter int IMAGE_WIDTH = 320
) (
  input  logic        clk,
  input  logic        rst,
  census3x3_if.slave  bus
);

  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [AW-1:0] LAST_COL = AW'(IMAGE_WIDTH - 1);

  // A window column is packed {top, mid, bot}; a window is packed {left, mid, right}.
  function automatic logic [7:0] census_code(input logic [71:0] win, input logic top_out,
                                             input logic left_out, input logic right_out);
    logic [7:0] c;
    logic [7:0] code;
    logic [7:0] mask;
    c       = win[39:32];
    code[7] = win[71:64] < c;
    code[6] = win[47:40] < c;
    code[5] = win[23:16] < c;
    code[4] = win[63:56] < c;
    code[3] = win[15:8]  < c;
    code[2] = win[55:48] < c;
    code[1] = win[31:24] < c;
    code[0] = win[7:0]   < c;
    mask = (top_out   ? 8'b0001_1111 : 8'b1111_1111)
         & (left_out  ? 8'b0110_1011 : 8'b1111_1111)
         & (right_out ? 8'b1101_0110 : 8'b1111_1111);
    return code & mask;
  endfunction

  logic          accept_s;
  logic [7:0]    lb1_rd_s, lb2_rd_s;
  logic [7:0]    lb1_q [IMAGE_WIDTH];
  logic [7:0]    lb2_q [IMAGE_WIDTH];

  logic [AW-1:0] col_q, col_d;
  logic [15:0]   row_q, row_d;
  logic [23:0]   sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic          a_emit_q, a_emit_d, a_extra_q, a_extra_d;
  logic [15:0]   a_row_q, a_row_d;
  logic [AW-1:0] a_col_q, a_col_d;

  logic [71:0]   win_q, win_d;
  logic          s0_valid_q, s0_valid_d, s0_pend_q, s0_pend_d;
  logic          s0_top_out_q, s0_top_out_d, s0_left_out_q, s0_left_out_d;
  logic          s0_right_out_q, s0_right_out_d;
  logic [15:0]   s0_row_q, s0_row_d;
  logic [AW-1:0] s0_col_q, s0_col_d;

  logic          census_valid_q, census_valid_d;
  logic [15:0]   census_out_q, census_out_d;
  logic [15:0]   center_row_s1, center_row_s1_d;
  logic [15:0]   center_col_s1, center_col_s1_d;

  assign accept_s = bus.gray_valid;
  assign lb1_rd_s = lb1_q[col_q];
  assign lb2_rd_s = lb2_q[col_q];
  assign bus.census_valid = census_valid_q;
  assign bus.census_out   = census_out_q;

  // Input counters, column shift registers and emission decision for the accepted pixel.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    a_emit_d  = 1'b0;
    a_extra_d = 1'b0;
    a_row_d   = row_q - 16'd1;
    a_col_d   = col_q - AW'(1);
    if (accept_s) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + 16'd1;
      end else begin
        col_d = col_q + AW'(1);
      end
      sh0_d     = {lb2_rd_s, lb1_rd_s, bus.gray};
      sh1_d     = sh0_q;
      sh2_d     = sh1_q;
      a_emit_d  = (row_q != 16'd0) && (col_q != '0);
      a_extra_d = (row_q != 16'd0) && (col_q == LAST_COL);
    end else begin
      a_emit_d  = 1'b0;
    end
  end

  // Window capture; the end-of-line centre reuses the previous window shifted left one column.
  always_comb begin
    win_d          = win_q;
    s0_valid_d     = 1'b0;
    s0_pend_d      = 1'b0;
    s0_row_d       = s0_row_q;
    s0_col_d       = s0_col_q;
    s0_top_out_d   = s0_top_out_q;
    s0_left_out_d  = s0_left_out_q;
    s0_right_out_d = s0_right_out_q;
    if (a_emit_q) begin
      win_d          = {sh2_q, sh1_q, sh0_q};
      s0_valid_d     = 1'b1;
      s0_pend_d      = a_extra_q;
      s0_row_d       = a_row_q;
      s0_col_d       = a_col_q;
      s0_top_out_d   = (a_row_q == 16'd0);
      s0_left_out_d  = (a_col_q == '0);
      s0_right_out_d = 1'b0;
    end else if (s0_pend_q) begin
      win_d          = {win_q[47:0], 24'd0};
      s0_valid_d     = 1'b1;
      s0_col_d       = s0_col_q + AW'(1);
      s0_left_out_d  = 1'b0;
      s0_right_out_d = 1'b1;
    end else begin
      s0_valid_d     = 1'b0;
    end
  end

  // Code register stage; outputs hold between strobes.
  always_comb begin
    census_valid_d  = 1'b0;
    census_out_d    = census_out_q;
    center_row_s1_d = center_row_s1;
    center_col_s1_d = center_col_s1;
    if (s0_valid_q) begin
      census_valid_d  = 1'b1;
      census_out_d    = {8'd0, census_code(win_q, s0_top_out_q, s0_left_out_q, s0_right_out_q)};
      center_row_s1_d = s0_row_q;
      center_col_s1_d = 16'(s0_col_q);
    end else begin
      census_valid_d  = 1'b0;
    end
  end

  // Line buffers: row r-1 moves down to the r-2 buffer as row r is written.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_q[col_q] <= bus.gray;
      lb2_q[col_q] <= lb1_rd_s;
    end
  end

  // Pipeline and counter state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q          <= '0;
      row_q          <= 16'd0;
      sh0_q          <= 24'd0;
      sh1_q          <= 24'd0;
      sh2_q          <= 24'd0;
      a_emit_q       <= 1'b0;
      a_extra_q      <= 1'b0;
      a_row_q        <= 16'd0;
      a_col_q        <= '0;
      win_q          <= 72'd0;
      s0_valid_q     <= 1'b0;
      s0_pend_q      <= 1'b0;
      s0_row_q       <= 16'd0;
      s0_col_q       <= '0;
      s0_top_out_q   <= 1'b0;
      s0_left_out_q  <= 1'b0;
      s0_right_out_q <= 1'b0;
      census_valid_q <= 1'b0;
      census_out_q   <= 16'd0;
      center_row_s1  <= 16'd0;
      center_col_s1  <= 16'd0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      sh0_q          <= sh0_d;
      sh1_q          <= sh1_d;
      sh2_q          <= sh2_d;
      a_emit_q       <= a_emit_d;
      a_extra_q      <= a_extra_d;
      a_row_q        <= a_row_d;
      a_col_q        <= a_col_d;
      win_q          <= win_d;
      s0_valid_q     <= s0_valid_d;
      s0_pend_q      <= s0_pend_d;
      s0_row_q       <= s0_row_d;
      s0_col_q       <= s0_col_d;
      s0_top_out_q   <= s0_top_out_d;
      s0_left_out_q  <= s0_left_out_d;
      s0_right_out_q <= s0_right_out_d;
      census_valid_q <= census_valid_d;
      census_out_q   <= census_out_d;
      center_row_s1  <= center_row_s1_d;
      center_col_s1  <= center_col_s1_d;
    end
  end

endmodule

// File: tb/tb_census3x3.sv
// Scoreboard bench for census3x3: a pixel-array reference model queues expected codes,
// coordinates and arrival cycles; a negedge monitor pops and compares each strobe.
module tb_census3x3;
  localparam int W    = 6;
  localparam int MAXR = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  census3x3_if bus_if ();
  census3x3 #(.IMAGE_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct {
    logic [15:0] code;
    int          row;
    int          col;
    int          when;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          img [MAXR][W];
  int          pix [MAXR][W];
  int          mr = 0;
  int          mc = 0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] last_exp = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  // Census code of centre (r,c) straight from the neighbourhood definition.
  function automatic logic [15:0] ref_code(int r, int c);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [15:0] code;
    code = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      int nr = r + dr[k];
      int nc = c + dc[k];
      if (nr >= 0 && nc >= 0 && nc < W && img[nr][nc] < img[r][c]) code[7-k] = 1'b1;
    end
    return code;
  endfunction

  task automatic check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Drive one pixel (caller sits at posedge+2), queue its emissions, then idle gap cycles.
  task automatic send(int p, int gap);
    bus_if.gray_valid = 1'b1;
    bus_if.gray       = 8'(p);
    img[mr][mc]       = p;
    if (mr >= 1 && mc >= 1)
      q.push_back('{ref_code(mr - 1, mc - 1), mr - 1, mc - 1, cyc + 3});
    if (mr >= 1 && mc == W - 1)
      q.push_back('{ref_code(mr - 1, W - 1), mr - 1, W - 1, cyc + 4});
    if (mc == W - 1) begin
      mc = 0;
      mr = mr + 1;
    end else begin
      mc = mc + 1;
    end
    @(posedge clk); #2;
    bus_if.gray_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    bus_if.gray_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #2;
    q.delete();
    last_exp = 16'h0000;
    mr = 0;
    mc = 0;
    check("rst_valid", int'(bus_if.census_valid), 0);
    check("rst_out", int'(bus_if.census_out), 0);
    check("rst_row", int'(dut.center_row_s1), 0);
    check("rst_col", int'(dut.center_col_s1), 0);
    rst = 1'b1;
  endtask

  // Monitor: every strobe must match the queue head in code, coordinates and cycle.
  always @(negedge clk) begin
    if (rst && cyc > 1) begin
      if (bus_if.census_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("code", int'(bus_if.census_out), int'(mon_e.code));
          check("center_row", int'(dut.center_row_s1), mon_e.row);
          check("center_col", int'(dut.center_col_s1), mon_e.col);
          check("latency_cycle", cyc, mon_e.when);
          last_exp = mon_e.code;
        end
      end else begin
        if (q.size() > 0 && cyc >= q[0].when) begin
          mon_e = q.pop_front();
          check("missing_valid", 0, 1);
        end
        check("hold_out", int'(bus_if.census_out), int'(last_exp));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.gray_valid = 1'b0;
    bus_if.gray       = 8'd0;
    do_reset();

    // Uniform frame: every code zero.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) send(128, 0);
    do_reset();

    // Single dark pixel at (2,2) on a background of 10.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++) send((r == 2 && c == 2) ? 5 : 10, 0);
    do_reset();

    // Bright centres: interior (2,3) gives 0xFF, column-0 (3,0) gives 0x6B.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < W; c++)
        send(((r == 2 && c == 3) || (r == 3 && c == 0)) ? 200 : 100, 0);
    do_reset();

    // Same low-range random frame, back-to-back then with random gaps.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++) pix[r][c] = int'($urandom_range(0, 7));
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++) send(pix[r][c], 0);
    do_reset();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++) send(pix[r][c], int'($urandom_range(0, 3)));
    do_reset();

    // Abandon a frame mid-row 2, then run a fresh full-range frame.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if (r < 2 || c < 4) send(int'($urandom_range(0, 255)), 0);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      check("post_rst_valid", int'(bus_if.census_valid), 0);
    end
    @(posedge clk); #2;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) send(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));

    repeat (10) begin @(posedge clk); #2; end
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
